// File: rtl/rx_frame_ctrl.sv
// Receive frame controller: hunts a sync byte, reads a length byte, writes payload bytes to the
// register field and raises a level interrupt with status. Define RX_CHECKSUM_EN for an XOR check.
module rx_frame_ctrl #(
  parameter logic [7:0]  SYNC_WORD   = 8'hA5,
  parameter logic [7:0]  BASE_ADDR   = 8'h00,
  parameter int unsigned MAX_LEN     = 32,
  parameter int unsigned BIT_TIMEOUT = 255
) (
  input  logic       G_CLK_RX,
  input  logic       reset,
  input  logic       rx_enable,
  input  logic       bitin,
  input  logic       bitsinc,
  input  logic       int_ack,
  output logic [7:0] rf_address,
  output logic [7:0] rf_data,
  output logic       rf_write_enable,
  output logic       interrupt,
  output logic [7:0] frame_len,
  output logic       rx_busy,
  output logic [4:0] status
);

  typedef enum logic [1:0] {
    StHunt,
    StLen,
    StPayload
`ifdef RX_CHECKSUM_EN
    , StCheck
`endif
  } state_e;

  localparam logic [3:0] EvOk      = 4'b0001;
  localparam logic [3:0] EvLenErr  = 4'b0010;
  localparam logic [3:0] EvTimeout = 4'b0100;
`ifdef RX_CHECKSUM_EN
  localparam logic [3:0] EvCksErr  = 4'b1000;
`endif

  state_e      state_q, state_d;
  logic [6:0]  sr_q, sr_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  len_q, len_d;
  logic [15:0] tmo_q, tmo_d;
  logic        we_q, we_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        int_q, int_d;
  logic [4:0]  status_q, status_d;
`ifdef RX_CHECKSUM_EN
  logic [7:0]  xor_q, xor_d;
`endif

  logic [7:0] byte_new;
  logic       byte_done;
  logic [3:0] ev;

  assign byte_new  = {sr_q, bitin};
  assign byte_done = bitsinc && (bit_cnt_q == 3'd7);

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    idx_d     = idx_q;
    len_d     = len_q;
    tmo_d     = tmo_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    ev        = '0;
`ifdef RX_CHECKSUM_EN
    xor_d     = xor_q;
`endif

    if (!rx_enable) begin
      state_d   = StHunt;
      sr_d      = '0;
      bit_cnt_d = '0;
      idx_d     = '0;
      tmo_d     = '0;
    end else begin
      if (bitsinc) begin
        sr_d      = byte_new[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      if (state_q != StHunt) begin
        tmo_d = bitsinc ? '0 : tmo_q + 16'd1;
      end

      case (state_q)
        StHunt: begin
          // Sliding window: no byte alignment until the sync pattern is seen.
          if (bitsinc && (byte_new == SYNC_WORD)) begin
            state_d   = StLen;
            bit_cnt_d = '0;
            tmo_d     = '0;
          end
        end
        StLen: begin
          if (byte_done) begin
            if ((byte_new == 8'd0) || (byte_new > 8'(MAX_LEN))) begin
              ev      = EvLenErr;
              state_d = StHunt;
            end else begin
              len_d   = byte_new;
              idx_d   = '0;
              state_d = StPayload;
`ifdef RX_CHECKSUM_EN
              xor_d   = byte_new;
`endif
            end
          end
        end
        StPayload: begin
          if (byte_done) begin
            we_d   = 1'b1;
            addr_d = BASE_ADDR + idx_q;
            data_d = byte_new;
            idx_d  = idx_q + 8'd1;
`ifdef RX_CHECKSUM_EN
            xor_d  = xor_q ^ byte_new;
`endif
            if (idx_q == len_q - 8'd1) begin
`ifdef RX_CHECKSUM_EN
              state_d = StCheck;
`else
              ev      = EvOk;
              state_d = StHunt;
`endif
            end
          end
        end
`ifdef RX_CHECKSUM_EN
        StCheck: begin
          if (byte_done) begin
            ev      = (byte_new == xor_q) ? EvOk : EvCksErr;
            state_d = StHunt;
          end
        end
`endif
        default: state_d = StHunt;
      endcase

      // Timeout only advances on cycles without a strobe, so it never collides with a byte event.
      if ((state_q != StHunt) && !bitsinc && (tmo_q == 16'(BIT_TIMEOUT - 1))) begin
        ev      = EvTimeout;
        state_d = StHunt;
      end
    end
  end

  always_comb begin
    int_d    = int_q;
    status_d = status_q;
    if (ev != 4'b0000) begin
      // A new event overrides a same-cycle acknowledge; overrun only if the old one stays unacked.
      int_d    = 1'b1;
      status_d = {int_q && !int_ack, ev};
    end else if (int_ack && int_q) begin
      int_d    = 1'b0;
      status_d = '0;
    end
  end

  always_ff @(posedge G_CLK_RX or posedge reset) begin
    if (reset) begin
      state_q   <= StHunt;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      idx_q     <= '0;
      len_q     <= '0;
      tmo_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      int_q     <= 1'b0;
      status_q  <= '0;
`ifdef RX_CHECKSUM_EN
      xor_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      tmo_q     <= tmo_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      int_q     <= int_d;
      status_q  <= status_d;
`ifdef RX_CHECKSUM_EN
      xor_q     <= xor_d;
`endif
    end
  end

  assign rf_address      = addr_q;
  assign rf_data         = data_q;
  assign rf_write_enable = we_q;
  assign interrupt       = int_q;
  assign frame_len       = len_q;
  assign rx_busy         = (state_q != StHunt);
  assign status          = status_q;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Bench for rx_frame_ctrl: directed and random frames checked against a frame-level model
// of expected register writes, interrupt and status.
module tb_rx_frame_ctrl;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam logic [7:0] BASE = 8'h00;
  localparam int         MAXL = 32;
  localparam int         TMO  = 255;

  logic       clk = 1'b0;
  logic       reset, rx_enable, bitin, bitsinc, int_ack;
  logic [7:0] rf_address, rf_data, frame_len;
  logic       rf_write_enable, interrupt, rx_busy;
  logic [4:0] status;

  rx_frame_ctrl #(
    .SYNC_WORD  (SYNC),
    .BASE_ADDR  (BASE),
    .MAX_LEN    (MAXL),
    .BIT_TIMEOUT(TMO)
  ) dut (
    .G_CLK_RX       (clk),
    .reset          (reset),
    .rx_enable      (rx_enable),
    .bitin          (bitin),
    .bitsinc        (bitsinc),
    .int_ack        (int_ack),
    .rf_address     (rf_address),
    .rf_data        (rf_data),
    .rf_write_enable(rf_write_enable),
    .interrupt      (interrupt),
    .frame_len      (frame_len),
    .rx_busy        (rx_busy),
    .status         (status)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] wq[$];
  logic        last_wr_int = 1'b0;
  logic [7:0]  pay[$];

  // Model state
  logic       m_int;
  logic [4:0] m_status;
  logic [7:0] m_flen;

  always @(negedge clk) begin
    if (rf_write_enable) begin
      wq.push_back({rf_address, rf_data});
      last_wr_int = interrupt;
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic ack);
    int gap;
    gap = $urandom_range(0, 3);
    repeat (gap) tick();
    bitin   = b;
    bitsinc = 1'b1;
    int_ack = ack;
    tick();
    bitsinc = 1'b0;
    int_ack = 1'b0;
    bitin   = 1'($urandom);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ack_last);
    for (int i = 7; i >= 0; i--) send_bit(b[i], ack_last && (i == 0));
  endtask

  // Eight zero bits cannot complete a false sync match with whatever precedes them.
  task automatic preamble();
    for (int i = 0; i < 8; i++) send_bit(1'b0, 1'b0);
  endtask

  task automatic do_ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    if (m_int) begin
      m_int    = 1'b0;
      m_status = '0;
    end
    check("ack_int", 16'(interrupt), 16'(m_int));
    check("ack_status", 16'(status), 16'(m_status));
  endtask

  task automatic fill_random(input int len);
    pay.delete();
    for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
  endtask

  task automatic run_frame(input string tag, input logic [7:0] len, input bit corrupt,
                           input bit ack_ev, input bit noise);
    logic [15:0] exp_w[$];
    logic [7:0]  bytes[$];
    logic [7:0]  cks;
    logic [3:0]  ev;
    bit          legal;
    legal = (len != 8'd0) && (int'(len) <= MAXL);
    bytes.push_back(SYNC);
    bytes.push_back(len);
    if (legal) begin
      cks = len;
      for (int i = 0; i < int'(len); i++) begin
        bytes.push_back(pay[i]);
        exp_w.push_back({BASE + 8'(i), pay[i]});
        cks = cks ^ pay[i];
      end
`ifdef RX_CHECKSUM_EN
      bytes.push_back(corrupt ? (cks ^ 8'h01) : cks);
      ev = corrupt ? 4'b1000 : 4'b0001;
`else
      ev = corrupt ? 4'b0001 : 4'b0001;
`endif
      m_flen = len;
    end else begin
      ev = 4'b0010;
    end
    wq.delete();
    preamble();
    if (noise) begin
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
    end
    foreach (bytes[k]) send_byte(bytes[k], ack_ev && (k == bytes.size() - 1));
    m_status = {m_int && !ack_ev, ev};
    m_int    = 1'b1;
    tick();
    tick();
    check({tag, "_nwr"}, 16'(wq.size()), 16'(exp_w.size()));
    foreach (exp_w[k]) begin
      if (k < wq.size()) check($sformatf("%s_wr%0d", tag, k), wq[k], exp_w[k]);
    end
    check({tag, "_int"}, 16'(interrupt), 16'(m_int));
    check({tag, "_status"}, 16'(status), 16'(m_status));
    check({tag, "_flen"}, 16'(frame_len), 16'(m_flen));
    check({tag, "_busy"}, 16'(rx_busy), 16'd0);
`ifndef RX_CHECKSUM_EN
    if (legal) check({tag, "_int_at_last_wr"}, 16'(last_wr_int), 16'd1);
`endif
  endtask

  initial begin
    reset     = 1'b1;
    rx_enable = 1'b1;
    bitin     = 1'b0;
    bitsinc   = 1'b0;
    int_ack   = 1'b0;
    m_int     = 1'b0;
    m_status  = '0;
    m_flen    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_addr", 16'(rf_address), 16'd0);
    check("rst_data", 16'(rf_data), 16'd0);
    check("rst_we", 16'(rf_write_enable), 16'd0);
    check("rst_int", 16'(interrupt), 16'd0);
    check("rst_flen", 16'(frame_len), 16'd0);
    check("rst_busy", 16'(rx_busy), 16'd0);
    check("rst_status", 16'(status), 16'd0);
    reset = 1'b0;
    tick();

    // Basic three-byte frame
    pay = '{8'h11, 8'h22, 8'h33};
    run_frame("basic", 8'd3, 1'b0, 1'b0, 1'b0);
    check("basic_status_const", 16'(status), 16'h0001);
    do_ack();

    // Length errors: zero and just above the limit
    run_frame("len0", 8'h00, 1'b0, 1'b0, 1'b1);
    check("len0_status_const", 16'(status), 16'h0002);
    do_ack();
    run_frame("len21", 8'h21, 1'b0, 1'b0, 1'b0);
    do_ack();
    fill_random(MAXL);
    run_frame("lenmax", 8'(MAXL), 1'b0, 1'b0, 1'b0);
    do_ack();

    // Timeout after one of two payload bytes
    wq.delete();
    preamble();
    send_byte(SYNC, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h7E, 1'b0);
    check("tmo_busy_mid", 16'(rx_busy), 16'd1);
    repeat (TMO - 1) tick();
    check("tmo_early_int", 16'(interrupt), 16'd0);
    tick();
    m_int = 1'b1; m_status = 5'b00100; m_flen = 8'h02;
    check("tmo_int", 16'(interrupt), 16'(m_int));
    check("tmo_status", 16'(status), 16'(m_status));
    check("tmo_busy", 16'(rx_busy), 16'd0);
    check("tmo_nwr", 16'(wq.size()), 16'd1);
    if (wq.size() > 0) check("tmo_wr0", wq[0], {BASE, 8'h7E});
    check("tmo_flen", 16'(frame_len), 16'(m_flen));
    do_ack();

`ifdef RX_CHECKSUM_EN
    pay = '{8'h10, 8'h20};
    run_frame("cks_ok", 8'd2, 1'b0, 1'b0, 1'b0);
    check("cks_ok_const", 16'(status), 16'h0001);
    do_ack();
    run_frame("cks_bad", 8'd2, 1'b1, 1'b0, 1'b0);
    check("cks_bad_const", 16'(status), 16'h0008);
    do_ack();
`endif

    // Overrun, then acknowledge colliding with a new event
    fill_random(4);
    run_frame("ovr1", 8'd4, 1'b0, 1'b0, 1'b0);
    fill_random(2);
    run_frame("ovr2", 8'd2, 1'b0, 1'b0, 1'b0);
    check("ovr2_const", 16'(status), 16'h0011);
    fill_random(3);
    run_frame("ackev", 8'd3, 1'b0, 1'b1, 1'b0);
    check("ackev_const", 16'(status), 16'h0001);

    // Asynchronous reset mid-payload with an interrupt pending
    preamble();
    send_byte(SYNC, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'hC3, 1'b0);
    send_byte(8'h3C, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    check("mid_busy", 16'(rx_busy), 16'd1);
    #2 reset = 1'b1;
    #1;
    check("arst_addr", 16'(rf_address), 16'd0);
    check("arst_data", 16'(rf_data), 16'd0);
    check("arst_int", 16'(interrupt), 16'd0);
    check("arst_status", 16'(status), 16'd0);
    check("arst_flen", 16'(frame_len), 16'd0);
    check("arst_busy", 16'(rx_busy), 16'd0);
    tick();
    reset = 1'b0;
    m_int = 1'b0; m_status = '0; m_flen = '0;
    tick();
    fill_random(4);
    run_frame("post_rst", 8'd4, 1'b0, 1'b0, 1'b0);
    do_ack();

    // rx_enable drop mid-frame: back to hunt, no event, no timeout later
    wq.delete();
    preamble();
    send_byte(SYNC, 1'b0);
    send_byte(8'h04, 1'b0);
    send_byte(8'h5A, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    rx_enable = 1'b0;
    tick();
    check("dis_busy", 16'(rx_busy), 16'd0);
    rx_enable = 1'b1;
    repeat (TMO + 20) tick();
    check("dis_int", 16'(interrupt), 16'd0);
    check("dis_status", 16'(status), 16'd0);
    check("dis_nwr", 16'(wq.size()), 16'd1);
    fill_random(5);
    run_frame("post_dis", 8'd5, 1'b0, 1'b0, 1'b0);

    // Random frames
    for (int f = 0; f < 20; f++) begin
      logic [7:0] len;
      len = 8'($urandom_range(0, MAXL + 4));
      fill_random(int'(len));
      if ($urandom_range(0, 1) == 1) do_ack();
      run_frame($sformatf("rnd%0d", f), len, 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rx_frame_ctrl.md
Name: rx_frame_ctrl

Overview:
Receive-side frame controller between the demodulator bit stream (bitout/bitsinc) and the register field. Hunts for a sync byte, reads a length byte, then assembles payload bytes MSB-first. Each payload byte is written into the register field at sequential addresses. Raises a level interrupt with latched status at frame end, which the host clears with an acknowledge.

Parameters:
SYNC_WORD, 8'hA5, sync byte searched for in HUNT
BASE_ADDR, 8'h00, register-field address of payload byte 0
MAX_LEN, 32, largest legal payload length (1..255)
BIT_TIMEOUT, 255, max G_CLK_RX cycles allowed between bitsinc pulses inside a frame

Ports:
G_CLK_RX  in  1  receive clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
rx_enable  in  1  1 = controller runs; 0 = forced to HUNT, no event
bitin  in  1  demodulated data bit, valid when bitsinc=1
bitsinc  in  1  one-cycle bit strobe from demodulator
int_ack  in  1  host acknowledge; clears interrupt and status
rf_address  out  8  register-field write address
rf_data  out  8  register-field write data
rf_write_enable  out  1  one-cycle write strobe
interrupt  out  1  level, frame event pending
frame_len  out  8  length byte of last frame that reached PAYLOAD
rx_busy  out  1  1 in any state except HUNT
status  out  5  [0] ok, [1] length err, [2] timeout, [3] checksum err, [4] overrun

Behaviour:
- Reset: state=HUNT, shift reg=0, bit/byte counters=0, all outputs 0.
- Bits are sampled only on cycles with bitsinc=1, shifted in MSB-first. Byte complete on the 8th sampled bit.
- HUNT: 8-bit sliding window compared after every sampled bit. On match with SYNC_WORD -> LEN, bit counter cleared. No byte alignment is assumed before the match.
- LEN: on byte complete, len=0 or len>MAX_LEN -> event "length err", go to HUNT. Otherwise latch frame_len, idx=0, -> PAYLOAD.
- PAYLOAD: on each byte complete, next cycle rf_write_enable=1, rf_address=BASE_ADDR+idx (8-bit wrap), rf_data=byte; idx++.
  - rf_address/rf_data hold their values until the next write.
  - After byte len-1: -> CHECK if RX_CHECKSUM_EN, else event "ok" and -> HUNT.
- CHECK (macro only): byte equal to running XOR -> "ok", otherwise -> "checksum err"; -> HUNT either way.
- Timeout: in LEN/PAYLOAD/CHECK a counter increments every cycle without bitsinc and clears on bitsinc. Reaching BIT_TIMEOUT -> event "timeout", -> HUNT. Bytes already written stay written.
- Event: the cycle after the triggering bitsinc (or timeout), interrupt=1 and status is loaded with the event bit.
  - If interrupt was already 1: status[4]=1 and bits [3:0] are replaced by the new event.
- int_ack while interrupt=1: interrupt and status clear next cycle. A simultaneous event wins: interrupt stays 1, status loads the new event, status[4]=0.
- The final payload write and the "ok" interrupt occur in the same cycle.
- rx_enable=0: next cycle state=HUNT, counters clear, no event, no write. Interrupt/status are untouched.
- Asynchronous reset mid-frame: immediate return to the reset state. No write, no event.
- rx_busy=1 in LEN/PAYLOAD/CHECK.

Optional Feature:
RX_CHECKSUM_EN
- Defined: a check byte follows the payload. Running XOR covers the length byte and all payload bytes. Mismatch raises "checksum err". Payload bytes are still written to the register field.
- Undefined: no CHECK state, frame ends after the last payload byte, status[3] is tied to 0.

Test Plan:
- Bits A5,03,11,22,33 (no macro) -> writes (00,11),(01,22),(02,33) on consecutive byte boundaries; interrupt=1, status=5'b00001, frame_len=3.
- Noise bits 1,0,1 then A5,00 -> no writes; interrupt=1, status=5'b00010. Repeat with length 8'h21 (33 > MAX_LEN) -> same status.
- A5,02,7E then no bitsinc for 255 cycles -> one write (00,7E); status=5'b00100; rx_busy=0.
- RX_CHECKSUM_EN: A5,02,10,20,check=32 -> status ok. Same frame with check=33 -> status=5'b01000, writes still done.
- Two good frames, no int_ack between them -> second event gives status=5'b10001. int_ack asserted on the same cycle as a third event -> interrupt stays 1, status=5'b00001.
- Reset asserted mid-PAYLOAD -> all outputs 0 immediately; after release, a following frame is received normally.
